// File: rtl/lsu.sv
// Load/store unit between the execute stage and the unified RAM data port.
// One request is handled at a time. Byte and halfword stores become a word
// read-modify-write. Loads are sign- or zero-extended from their byte lane.
// The PC is stalled while an access is in flight. Misaligned or undefined
// accesses are rejected without touching the RAM.
//
// Request handshake: req_load / req_store are levels. The requester holds them
// until it sees a one-cycle done or err pulse. They are sampled only in IDLE.
module lsu #(
   parameter int ADDR_W = 6
) (
   input  logic              clk,
   input  logic              nRst,
   input  logic              req_load,
   input  logic              req_store,
   input  logic [2:0]        funct3,
   input  logic [31:0]       addr,
   input  logic [31:0]       store_data,
   input  logic [31:0]       mem_rdata,
   output logic              mem_read_enable,
   output logic              mem_write_enable,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   output logic [31:0]       load_data,
   output logic              stall,
   output logic              done,
   output logic              err
);

   typedef enum logic [2:0] {
      S_IDLE, S_RD, S_RDW, S_WR, S_DONE, S_ERR
   } state_t;

   state_t            state_q;
   logic [ADDR_W-1:0] addr_q;
   logic [2:0]        funct3_q;
   logic              is_store_q;
   logic [15:0]       store_data_q;  // only the sub-word lanes are needed later
   logic [31:0]       wdata_q;       // SW data or merged RMW word
   logic [31:0]       load_data_q;

   logic              illegal;
   logic [7:0]        byte_sel;
   logic [15:0]       half_sel;
   logic [31:0]       ext_load;
   logic [31:0]       merged;
   logic              unused_addr;

   // Upper address bits lie outside the RAM and are deliberately ignored.
   assign unused_addr = ^addr[31:ADDR_W];

   // Classify the presented request as legal or rejected.
   always_comb begin
      illegal = 1'b0;
      if (req_load && req_store) illegal = 1'b1;
      case (funct3)
         3'b011, 3'b110, 3'b111: illegal = 1'b1;
         3'b100, 3'b101:         if (req_store) illegal = 1'b1;
         default:                ;
      endcase
      if ((funct3 == 3'b001 || funct3 == 3'b101) && addr[0]) illegal = 1'b1;
      if (funct3 == 3'b010 && addr[1:0] != 2'b00)            illegal = 1'b1;
   end

   // Lane selection for loads and lane merge for sub-word stores.
   always_comb begin
      byte_sel = mem_rdata[{addr_q[1:0], 3'b000} +: 8];
      half_sel = addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
      case (funct3_q)
         3'b000:  ext_load = {{24{byte_sel[7]}}, byte_sel};
         3'b100:  ext_load = {24'b0, byte_sel};
         3'b001:  ext_load = {{16{half_sel[15]}}, half_sel};
         3'b101:  ext_load = {16'b0, half_sel};
         default: ext_load = mem_rdata;
      endcase
      merged = mem_rdata;
      if (funct3_q[1:0] == 2'b00) begin
         merged[{addr_q[1:0], 3'b000} +: 8] = store_data_q[7:0];
      end else if (addr_q[1]) begin
         merged[31:16] = store_data_q;
      end else begin
         merged[15:0] = store_data_q;
      end
   end

   // Access sequencer: latches the request in IDLE and walks RD/RDW/WR.
   always_ff @(posedge clk or negedge nRst) begin
      if (!nRst) begin
         state_q      <= S_IDLE;
         addr_q       <= '0;
         funct3_q     <= 3'b000;
         is_store_q   <= 1'b0;
         store_data_q <= 16'h0;
         wdata_q      <= 32'h0;
         load_data_q  <= 32'h0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (req_load || req_store) begin
                  addr_q       <= addr[ADDR_W-1:0];
                  funct3_q     <= funct3;
                  is_store_q   <= req_store;
                  store_data_q <= store_data[15:0];
                  if (illegal) begin
                     state_q <= S_ERR;
                  end else if (req_store && funct3 == 3'b010) begin
                     wdata_q <= store_data;
                     state_q <= S_WR;
                  end else begin
                     state_q <= S_RD;
                  end
               end
            end
            S_RD:  state_q <= S_RDW;
            S_RDW: begin
               if (is_store_q) begin
                  wdata_q <= merged;
                  state_q <= S_WR;
               end else begin
                  load_data_q <= ext_load;
                  state_q     <= S_DONE;
               end
            end
            S_WR:    state_q <= S_DONE;
            S_DONE:  state_q <= S_IDLE;
            S_ERR:   state_q <= S_IDLE;
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign mem_read_enable  = (state_q == S_RD);
   assign mem_write_enable = (state_q == S_WR);
   assign done             = (state_q == S_DONE);
   assign err              = (state_q == S_ERR);
   assign mem_addr         = {addr_q[ADDR_W-1:2], 2'b00};
   assign mem_wdata        = wdata_q;
   assign load_data        = load_data_q;
   // Reset forces stall low even while a request is still presented.
   assign stall = nRst & (((state_q == S_IDLE) && (req_load || req_store)) ||
                          (state_q == S_RD) || (state_q == S_RDW) ||
                          (state_q == S_WR));

endmodule

// File: tb/tb_lsu.sv
// Directed bench for lsu with a registered-read RAM model.
module tb_lsu;
   logic        clk = 1'b0;
   logic        nRst = 1'b0;
   logic        req_load = 1'b0, req_store = 1'b0;
   logic [2:0]  funct3 = 3'b000;
   logic [31:0] addr = 32'h0, store_data = 32'h0;
   logic [31:0] mem_rdata;
   logic        mem_read_enable, mem_write_enable;
   logic [5:0]  mem_addr;
   logic [31:0] mem_wdata, load_data;
   logic        stall, done, err;

   logic [31:0] ram [16];
   int checks = 0, failures = 0;

   // per-access record
   int          done_cyc, err_cyc, rd_cyc, wr_cyc, rd_cnt, wr_cnt;
   logic [5:0]  rd_addr, wr_addr;
   logic [31:0] wr_data;
   logic [15:0] stall_m;

   lsu #(.ADDR_W(6)) dut (
      .clk(clk), .nRst(nRst), .req_load(req_load), .req_store(req_store),
      .funct3(funct3), .addr(addr), .store_data(store_data),
      .mem_rdata(mem_rdata), .mem_read_enable(mem_read_enable),
      .mem_write_enable(mem_write_enable), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .load_data(load_data), .stall(stall),
      .done(done), .err(err)
   );

   // clock
   always #5 clk = ~clk;

   // RAM: data_out registered one cycle after read_enable
   always @(posedge clk) begin
      if (mem_read_enable)  mem_rdata <= ram[mem_addr[5:2]];
      if (mem_write_enable) ram[mem_addr[5:2]] <= mem_wdata;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic sample(input int c);
      if (mem_read_enable)  begin rd_cnt++; if (rd_cyc < 0) begin rd_cyc = c; rd_addr = mem_addr; end end
      if (mem_write_enable) begin wr_cnt++; if (wr_cyc < 0) begin wr_cyc = c; wr_addr = mem_addr; wr_data = mem_wdata; end end
      if (done && done_cyc < 0) done_cyc = c;
      if (err && err_cyc < 0)   err_cyc = c;
      stall_m[c] = stall;
   endtask

   task automatic clear_rec();
      done_cyc = -1; err_cyc = -1; rd_cyc = -1; wr_cyc = -1;
      rd_cnt = 0; wr_cnt = 0; stall_m = '0; rd_addr = '0; wr_addr = '0; wr_data = '0;
   endtask

   // Drive one request; cycle 0 is the acceptance cycle. Bounded at 10 cycles.
   task automatic run_access(input logic ld, input logic st, input logic [2:0] f3,
                             input logic [31:0] a, input logic [31:0] sd);
      clear_rec();
      @(negedge clk);
      req_load = ld; req_store = st; funct3 = f3; addr = a; store_data = sd;
      for (int c = 0; c < 10; c++) begin
         if (c > 0) @(negedge clk);
         #1;
         sample(c);
         if (done || err) begin
            req_load = 1'b0; req_store = 1'b0;
            break;
         end
      end
      req_load = 1'b0; req_store = 1'b0;
   endtask

   initial begin
      // reset state
      #12;
      check("rst_rd_en", {31'b0, mem_read_enable}, 32'd0);
      check("rst_wr_en", {31'b0, mem_write_enable}, 32'd0);
      check("rst_done_err_stall", {29'b0, done, err, stall}, 32'd0);
      check("rst_addr", {26'b0, mem_addr}, 32'd0);
      check("rst_wdata", mem_wdata, 32'd0);
      check("rst_load_data", load_data, 32'd0);
      @(negedge clk);
      for (int i = 0; i < 16; i++) ram[i] <= 32'h0;
      ram[2] <= 32'h8877_6655;
      ram[1] <= 32'h1122_3344;
      nRst = 1'b1;

      // LW at 0x08
      run_access(1'b1, 1'b0, 3'b010, 32'h08, 32'h0);
      check("lw_rd_cyc", rd_cyc, 1);
      check("lw_rd_cnt", rd_cnt, 1);
      check("lw_rd_addr", {26'b0, rd_addr}, 32'h08);
      check("lw_wr_cnt", wr_cnt, 0);
      check("lw_done_cyc", done_cyc, 3);
      check("lw_data", load_data, 32'h8877_6655);
      check("lw_stall", {16'b0, stall_m}, 32'h0007);

      @(negedge clk);
      ram[2] <= 32'h80FF_7F01;
      run_access(1'b1, 1'b0, 3'b000, 32'h0B, 32'h0);
      check("lb_done_cyc", done_cyc, 3);
      check("lb_data", load_data, 32'hFFFF_FF80);
      run_access(1'b1, 1'b0, 3'b100, 32'h0B, 32'h0);
      check("lbu_data", load_data, 32'h0000_0080);
      run_access(1'b1, 1'b0, 3'b001, 32'h0A, 32'h0);
      check("lh_data", load_data, 32'hFFFF_80FF);
      run_access(1'b1, 1'b0, 3'b101, 32'h0A, 32'h0);
      check("lhu_done_cyc", done_cyc, 3);
      check("lhu_data", load_data, 32'h0000_80FF);

      // SB 0xAB at 0x05 onto 0x11223344
      run_access(1'b0, 1'b1, 3'b000, 32'h05, 32'h0000_00AB);
      check("sb_rd_cyc", rd_cyc, 1);
      check("sb_wr_cyc", wr_cyc, 3);
      check("sb_wr_cnt", wr_cnt, 1);
      check("sb_wr_addr", {26'b0, wr_addr}, 32'h04);
      check("sb_wdata", wr_data, 32'h1122_AB44);
      check("sb_done_cyc", done_cyc, 4);
      check("sb_ram", ram[1], 32'h1122_AB44);
      check("sb_load_kept", load_data, 32'h0000_80FF);

      // SW 0xDEADBEEF at 0x10
      run_access(1'b0, 1'b1, 3'b010, 32'h10, 32'hDEAD_BEEF);
      check("sw_rd_cnt", rd_cnt, 0);
      check("sw_wr_cyc", wr_cyc, 1);
      check("sw_wdata", wr_data, 32'hDEAD_BEEF);
      check("sw_done_cyc", done_cyc, 2);
      check("sw_ram", ram[4], 32'hDEAD_BEEF);
      check("sw_stall", {16'b0, stall_m}, 32'h0003);

      // rejected accesses
      run_access(1'b1, 1'b0, 3'b001, 32'h03, 32'h0);
      check("err_lh_cyc", err_cyc, 1);
      check("err_lh_mem", rd_cnt + wr_cnt, 0);
      check("err_lh_stall", {16'b0, stall_m}, 32'h0001);
      run_access(1'b0, 1'b1, 3'b010, 32'h06, 32'h5555_5555);
      check("err_sw_cyc", err_cyc, 1);
      check("err_sw_mem", rd_cnt + wr_cnt, 0);
      run_access(1'b1, 1'b0, 3'b011, 32'h08, 32'h0);
      check("err_f3_cyc", err_cyc, 1);
      check("err_f3_mem", rd_cnt + wr_cnt, 0);
      run_access(1'b1, 1'b1, 3'b010, 32'h08, 32'h0);
      check("err_both_cyc", err_cyc, 1);
      check("err_both_mem", rd_cnt + wr_cnt, 0);
      check("err_load_kept", load_data, 32'h0000_80FF);
      check("err_ram4", ram[4], 32'hDEAD_BEEF);

      // reset during RDW of SH at 0x06
      clear_rec();
      @(negedge clk);
      req_store = 1'b1; funct3 = 3'b001; addr = 32'h06; store_data = 32'h0000_1234;
      @(negedge clk); #1; sample(1);
      check("rst_sh_rd_cyc", rd_cyc, 1);
      @(negedge clk); #1;
      nRst = 1'b0;
      #1;
      check("rst_sh_rd_wr", {30'b0, mem_read_enable, mem_write_enable}, 32'd0);
      check("rst_sh_flags", {29'b0, done, err, stall}, 32'd0);
      check("rst_sh_addr", {26'b0, mem_addr}, 32'd0);
      check("rst_sh_wdata", mem_wdata, 32'd0);
      check("rst_sh_load", load_data, 32'd0);
      req_store = 1'b0;
      @(negedge clk);
      nRst = 1'b1;
      wr_cnt = 0;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk); #1;
         if (mem_write_enable) wr_cnt++;
      end
      check("rst_sh_no_write", wr_cnt, 0);
      check("rst_sh_ram", ram[1], 32'h1122_AB44);

      // two LWs held back-to-back at 0x10
      clear_rec();
      begin
         int d1, d2, r2;
         d1 = -1; d2 = -1; r2 = -1;
         @(negedge clk);
         req_load = 1'b1; funct3 = 3'b010; addr = 32'h10;
         for (int c = 0; c < 14; c++) begin
            if (c > 0) @(negedge clk);
            #1;
            sample(c);
            if (mem_read_enable && c > 1) r2 = c;
            if (done) begin
               if (d1 < 0) d1 = c;
               else begin d2 = c; req_load = 1'b0; break; end
            end
         end
         req_load = 1'b0;
         check("b2b_done1", d1, 3);
         check("b2b_done2", d2, 7);
         check("b2b_read2", r2, 5);
         check("b2b_rd_cnt", rd_cnt, 2);
         check("b2b_stall_accept", {31'b0, stall_m[4]}, 32'd1);
         check("b2b_stall_done", {31'b0, stall_m[3]}, 32'd0);
         check("b2b_data", load_data, 32'hDEAD_BEEF);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
